// File: rtl/cache_l1_data_nway.sv
// N-way set-associative, write-back/write-allocate, blocking L1 data cache with round-robin
// replacement and a WB->REFILL miss FSM. `define CACHE_L1_DATA_PERF_EN adds hit/miss/wb counters.
module cache_l1_data_nway #(
  parameter int ADDR_W  = 19,
  parameter int BLOCK_W = 128,
  parameter int SETS    = 64,
  parameter int WAYS    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               core_req_i,
  input  logic               core_we_i,
  input  logic [1:0]         core_size_i,
  input  logic               core_signed_i,
  input  logic [ADDR_W-1:0]  core_addr_i,
  input  logic [63:0]        core_wdata_i,
  output logic               core_ready_o,
  output logic               core_valid_o,
  output logic [63:0]        core_rdata_o,
`ifdef CACHE_L1_DATA_PERF_EN
  output logic [31:0]        perf_hit_o,
  output logic [31:0]        perf_miss_o,
  output logic [31:0]        perf_wb_o,
`endif
  output logic               l2_req_o,
  output logic               l2_we_o,
  output logic [ADDR_W-1:0]  l2_addr_o,
  output logic [BLOCK_W-1:0] l2_wdata_o,
  input  logic               l2_ack_i,
  input  logic [BLOCK_W-1:0] l2_rdata_i
);
  localparam int OFF_W = $clog2(BLOCK_W/8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SH_W  = OFF_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL} state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
  } req_t;

  state_e                     state_q, state_d;
  req_t                       req_q, req_d;
  logic [WAY_W-1:0]           victim_q, victim_d;
  logic                       valid_out_q, valid_out_d;
  logic [63:0]                rdata_q, rdata_d;
  logic [WAYS-1:0][SETS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;

  logic [BLOCK_W-1:0] data_mem [WAYS][SETS];
  logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off, off_al;
  logic [SH_W-1:0]  sh;

  assign req_tag = req_q.addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_q.addr[OFF_W +: IDX_W];
  assign req_off = req_q.addr[OFF_W-1:0];
  // Natural alignment: offset bits below the access size are dropped.
  assign off_al  = req_off & ~OFF_W'((4'd1 << req_q.size) - 4'd1);
  assign sh      = {off_al, 3'b000};

  logic [WAYS-1:0] way_hit, way_free;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w]  = valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag);
    assign way_free[w] = !valid_q[w][req_idx];
  end

  logic             hit, any_free;
  logic [WAY_W-1:0] hit_way, free_way, victim_sel;
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    any_free = 1'b0;
    free_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (way_hit[w])  begin hit = 1'b1;      hit_way  = WAY_W'(w); end
      if (way_free[w]) begin any_free = 1'b1; free_way = WAY_W'(w); end
    end
    victim_sel = any_free ? free_way : rr_q[req_idx];
  end

  logic [BLOCK_W-1:0] hit_line, byte_mask, wr_bits, merged;
  logic [63:0]        lane, size_mask, ld_val;
  always_comb begin
    hit_line = data_mem[hit_way][req_idx];
    lane     = 64'(hit_line >> sh);
    unique case (req_q.size)
      2'd0: begin size_mask = 64'hFF;        ld_val = {{56{req_q.sgn & lane[7]}},  lane[7:0]};  end
      2'd1: begin size_mask = 64'hFFFF;      ld_val = {{48{req_q.sgn & lane[15]}}, lane[15:0]}; end
      2'd2: begin size_mask = 64'hFFFF_FFFF; ld_val = {{32{req_q.sgn & lane[31]}}, lane[31:0]}; end
      default: begin size_mask = '1;         ld_val = lane; end
    endcase
    byte_mask = BLOCK_W'(size_mask) << sh;
    wr_bits   = BLOCK_W'(req_q.wdata & size_mask) << sh;
    merged    = (hit_line & ~byte_mask) | wr_bits;
  end

  logic               mem_we, tag_we;
  logic [WAY_W-1:0]   mem_way;
  logic [BLOCK_W-1:0] mem_wdata;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    victim_d    = victim_q;
    valid_out_d = 1'b0;
    rdata_d     = '0;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    rr_d        = rr_q;
    mem_we      = 1'b0;
    tag_we      = 1'b0;
    mem_way     = hit_way;
    mem_wdata   = merged;
    unique case (state_q)
      S_IDLE: if (core_req_i) begin
        req_d.we    = core_we_i;
        req_d.size  = core_size_i;
        req_d.sgn   = core_signed_i;
        req_d.addr  = core_addr_i;
        req_d.wdata = core_wdata_i;
        state_d     = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          valid_out_d = 1'b1;
          state_d     = S_IDLE;
          if (req_q.we) begin
            mem_we                   = 1'b1;
            dirty_d[hit_way][req_idx] = 1'b1;
          end else begin
            rdata_d = ld_val;
          end
        end else begin
          victim_d = victim_sel;
          state_d  = (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx]) ? S_WB : S_REFILL;
        end
      end
      S_WB: if (l2_ack_i) state_d = S_REFILL;
      S_REFILL: if (l2_ack_i) begin
        mem_we    = 1'b1;
        tag_we    = 1'b1;
        mem_way   = victim_q;
        mem_wdata = l2_rdata_i;
        valid_d[victim_q][req_idx] = 1'b1;
        dirty_d[victim_q][req_idx] = 1'b0;
        if (WAYS > 1) rr_d[req_idx] = rr_q[req_idx] + WAY_W'(1);
        state_d   = S_LOOKUP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line storage is not reset; only the valid/dirty/RR state is.
  always_ff @(posedge clk_i) begin
    if (mem_we) data_mem[mem_way][req_idx] <= mem_wdata;
    if (tag_we) tag_mem[mem_way][req_idx]  <= req_tag;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      victim_q    <= '0;
      valid_out_q <= 1'b0;
      rdata_q     <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      victim_q    <= victim_d;
      valid_out_q <= valid_out_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      rr_q        <= rr_d;
    end
  end

  assign core_ready_o = (state_q == S_IDLE);
  assign core_valid_o = valid_out_q;
  assign core_rdata_o = rdata_q;
  assign l2_req_o     = (state_q == S_WB) || (state_q == S_REFILL);
  assign l2_we_o      = (state_q == S_WB);

  // Driven purely from state and latched request, so stable for the whole handshake.
  always_comb begin
    l2_addr_o  = '0;
    l2_wdata_o = '0;
    if (state_q == S_WB) begin
      l2_addr_o  = {tag_mem[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
      l2_wdata_o = data_mem[victim_q][req_idx];
    end else if (state_q == S_REFILL) begin
      l2_addr_o  = {req_tag, req_idx, {OFF_W{1'b0}}};
    end
  end

`ifdef CACHE_L1_DATA_PERF_EN
  logic        first_q, first_d;
  logic [31:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d, perf_wb_q, perf_wb_d;

  // first_q marks the initial lookup of a request so replays after refill are not counted.
  always_comb begin
    first_d     = first_q;
    perf_hit_d  = perf_hit_q;
    perf_miss_d = perf_miss_q;
    perf_wb_d   = perf_wb_q;
    if (state_q == S_IDLE && core_req_i) first_d = 1'b1;
    if (state_q == S_LOOKUP) begin
      first_d = 1'b0;
      if (first_q) begin
        if (hit) begin
          if (perf_hit_q != '1) perf_hit_d = perf_hit_q + 32'd1;
        end else begin
          if (perf_miss_q != '1) perf_miss_d = perf_miss_q + 32'd1;
          if (state_d == S_WB && perf_wb_q != '1) perf_wb_d = perf_wb_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_q     <= 1'b0;
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
      perf_wb_q   <= '0;
    end else begin
      first_q     <= first_d;
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
      perf_wb_q   <= perf_wb_d;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
  assign perf_wb_o   = perf_wb_q;
`endif

endmodule

// File: tb/tb_cache_l1_data_nway.sv
// Directed bench for cache_l1_data_nway: a byte-level memory/replacement model predicts load
// data, L2 transactions and latency; literal checks pin the model to hand-computed values.
module tb_cache_l1_data_nway;
  localparam int ADDR_W = 19, BLOCK_W = 128, SETS = 64, WAYS = 2;

  logic               clk = 1'b0;
  logic               rst_i, core_req_i, core_we_i, core_signed_i;
  logic [1:0]         core_size_i;
  logic [ADDR_W-1:0]  core_addr_i;
  logic [63:0]        core_wdata_i, core_rdata_o;
  logic               core_ready_o, core_valid_o;
  logic               l2_req_o, l2_we_o, l2_ack_i;
  logic [ADDR_W-1:0]  l2_addr_o;
  logic [BLOCK_W-1:0] l2_wdata_o, l2_rdata_i;
`ifdef CACHE_L1_DATA_PERF_EN
  logic [31:0]        perf_hit_o, perf_miss_o, perf_wb_o;
`endif

  always #5 clk = ~clk;

  cache_l1_data_nway #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_signed_i(core_signed_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_ready_o(core_ready_o), .core_valid_o(core_valid_o), .core_rdata_o(core_rdata_o),
`ifdef CACHE_L1_DATA_PERF_EN
    .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o), .perf_wb_o(perf_wb_o),
`endif
    .l2_req_o(l2_req_o), .l2_we_o(l2_we_o), .l2_addr_o(l2_addr_o), .l2_wdata_o(l2_wdata_o),
    .l2_ack_i(l2_ack_i), .l2_rdata_i(l2_rdata_i));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- model: L2 contents, architected memory, and per-set way bookkeeping ----
  logic [127:0] l2mem [int];
  logic [127:0] arch  [int];
  bit           m_valid [WAYS][SETS];
  bit           m_dirty [WAYS][SETS];
  int           m_tag   [WAYS][SETS];
  int           m_rr    [SETS];
  int           m_hit, m_miss, m_wb;

  typedef struct { bit we; int addr; logic [127:0] data; } txn_t;
  txn_t         exp_q [$];
  int           last_wb_addr;
  logic [127:0] last_wb_data;

  function automatic logic [127:0] l2_line(int a);
    if (l2mem.exists(a)) return l2mem[a];
    if (a == 'h40) return 128'h1122334455667788_99AABBCCDDEEFF00;
    return {32'hF0E1D2C3 ^ a, 32'h8796A5B4 + a, 32'h01234567 ^ (a << 3), 32'h89ABCDEF - a};
  endfunction

  function automatic logic [127:0] arch_line(int a);
    if (arch.exists(a)) return arch[a];
    return l2_line(a);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin m_valid[w][s] = 0; m_dirty[w][s] = 0; m_tag[w][s] = 0; end
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    arch.delete();
    exp_q.delete();
    m_hit = 0; m_miss = 0; m_wb = 0;
  endtask

  task automatic model_access(input bit we, input logic [1:0] sz, input bit sgn, input int addr,
                              input logic [63:0] wd, output logic [63:0] exp_rd);
    int nb, a, line, set, tag, way, off;
    logic [127:0] ln;
    nb = 1 << sz; a = addr & ~(nb - 1); line = a & ~15; off = a & 15;
    set = (a >> 4) % SETS; tag = a >> 10; way = -1;
    for (int w = 0; w < WAYS; w++) if (way < 0 && m_valid[w][set] && m_tag[w][set] == tag) way = w;
    if (way >= 0) m_hit++;
    else begin
      m_miss++;
      for (int w = 0; w < WAYS; w++) if (way < 0 && !m_valid[w][set]) way = w;
      if (way < 0) way = m_rr[set];
      if (m_valid[way][set] && m_dirty[way][set]) begin
        int vl;
        vl = (m_tag[way][set] << 10) | (set << 4);
        exp_q.push_back('{1'b1, vl, arch_line(vl)});
        m_wb++;
      end
      exp_q.push_back('{1'b0, line, 128'h0});
      m_valid[way][set] = 1; m_dirty[way][set] = 0; m_tag[way][set] = tag;
      m_rr[set] = (m_rr[set] + 1) % WAYS;
    end
    ln = arch_line(line);
    exp_rd = '0;
    for (int i = 0; i < nb; i++) begin
      if (we) ln[(off + i)*8 +: 8] = wd[i*8 +: 8];
      else    exp_rd[i*8 +: 8] = ln[(off + i)*8 +: 8];
    end
    if (we) begin arch[line] = ln; m_dirty[way][set] = 1; end
    else if (sgn && nb < 8 && exp_rd[nb*8-1]) exp_rd = exp_rd | (~64'h0 << (nb*8));
  endtask

  // Drives one request, acts as L2 (acks after `lat` wait cycles), checks everything seen.
  task automatic access(input bit we, input logic [1:0] sz, input bit sgn, input int addr,
                        input logic [63:0] wd, input int lat, output logic [63:0] got);
    logic [63:0]       exp_rd;
    logic [ADDR_W-1:0] hold_addr;
    int                ntx, cyc, wait_n, exp_lat;
    bit                in_txn, done;
    txn_t              cur;
    model_access(we, sz, sgn, addr, wd, exp_rd);
    ntx = exp_q.size();
    exp_lat = 2 + ntx * (lat + 1) + ((ntx > 0) ? 1 : 0);
    got = '0; wait_n = 0; hold_addr = '0;
    @(negedge clk);
    chk("ready_before_req", core_ready_o, 1);
    core_req_i = 1; core_we_i = we; core_size_i = sz; core_signed_i = sgn;
    core_addr_i = ADDR_W'(addr); core_wdata_i = wd;
    cyc = 0; in_txn = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      core_req_i = 0;
      if (l2_ack_i) begin l2_ack_i = 0; in_txn = 0; end
      if (l2_req_o) begin
        if (!in_txn) begin
          in_txn = 1; wait_n = 0; hold_addr = l2_addr_o;
          if (exp_q.size() == 0) chk("l2_unexpected_req", l2_req_o, 0);
          else begin
            cur = exp_q.pop_front();
            chk("l2_we", l2_we_o, cur.we);
            chk("l2_addr", l2_addr_o, cur.addr);
            if (cur.we) begin
              chk("l2_wb_data", l2_wdata_o, cur.data);
              last_wb_addr = int'(l2_addr_o); last_wb_data = l2_wdata_o;
              l2mem[cur.addr] = cur.data;
            end
          end
        end else chk("l2_addr_stable", l2_addr_o, hold_addr);
        if (wait_n == lat) begin
          l2_ack_i = 1;
          l2_rdata_i = l2_we_o ? '0 : l2_line(int'(l2_addr_o));
        end else wait_n++;
      end
      if (core_valid_o) begin
        done = 1; got = core_rdata_o;
        chk("rdata", core_rdata_o, exp_rd);
        chk("latency", cyc, exp_lat);
      end
    end
    if (!done) chk("core_valid_timeout", core_valid_o, 1);
    chk("l2_txn_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  logic [63:0] got;

  initial begin
    rst_i = 1; core_req_i = 0; core_we_i = 0; core_size_i = 0; core_signed_i = 0;
    core_addr_i = '0; core_wdata_i = '0; l2_ack_i = 0; l2_rdata_i = '0;
    last_wb_addr = 0; last_wb_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_i = 0;
    chk("rst_ready", core_ready_o, 1);
    chk("rst_valid", core_valid_o, 0);
    chk("rst_l2_req", l2_req_o, 0);
    chk("rst_rdata", core_rdata_o, 0);

    access(0, 2'd3, 0, 'h40, 0, 1, got);
    chk("lit_ld_miss", got, 64'h99AABBCCDDEEFF00);
    access(0, 2'd3, 0, 'h40, 0, 0, got);
    chk("lit_ld_hit", got, 64'h99AABBCCDDEEFF00);
    access(1, 2'd0, 0, 'h43, 64'h80, 0, got);
    access(0, 2'd0, 1, 'h43, 0, 0, got);
    chk("lit_lb", got, 64'hFFFF_FFFF_FFFF_FF80);
    access(0, 2'd0, 0, 'h43, 0, 0, got);
    chk("lit_lbu", got, 64'h80);
    access(0, 2'd3, 0, 'h440, 0, 0, got);
    access(0, 2'd3, 0, 'h840, 0, 2, got);
    chk("lit_wb_addr", last_wb_addr, 'h40);
    chk("lit_wb_data", last_wb_data, 128'h1122334455667788_99AABBCC80EEFF00);
    access(0, 2'd3, 0, 'h440, 0, 0, got);
    access(0, 2'd3, 0, 'h40, 0, 1, got);
    chk("lit_reload", got, 64'h99AABBCC80EEFF00);

    // Reset while a refill request is outstanding.
    @(negedge clk);
    core_req_i = 1; core_we_i = 0; core_size_i = 2'd3; core_addr_i = ADDR_W'('h440);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      core_req_i = 0;
      if (l2_req_o) break;
    end
    chk("rst_mid_req_seen", l2_req_o, 1);
    rst_i = 1;
    @(negedge clk);
    chk("rst_mid_l2_req", l2_req_o, 0);
    chk("rst_mid_ready", core_ready_o, 1);
    rst_i = 0;
    model_reset();

    access(0, 2'd3, 0, 'h840, 0, 1, got);
    access(1, 2'd1, 0, 'h84A, 64'h8001, 0, got);
    access(0, 2'd1, 1, 'h84A, 0, 0, got);
    chk("lit_lh", got, 64'hFFFF_FFFF_FFFF_8001);
    access(0, 2'd1, 1, 'h84B, 0, 0, got);
    chk("lit_lh_unaligned", got, 64'hFFFF_FFFF_FFFF_8001);
    access(0, 2'd2, 0, 'h848, 0, 0, got);
    access(1, 2'd2, 0, 'h84C, 64'h1234_5678_DEAD_BEEF, 0, got);
    access(0, 2'd2, 1, 'h84C, 0, 0, got);
    chk("lit_lw", got, 64'hFFFF_FFFF_DEAD_BEEF);
    access(0, 2'd2, 0, 'h84C, 0, 0, got);
    chk("lit_lwu", got, 64'h0000_0000_DEAD_BEEF);
    access(1, 2'd3, 0, 'h848, 64'h0123_4567_89AB_CDEF, 0, got);
    access(0, 2'd3, 0, 'h848, 0, 0, got);
    chk("lit_ld", got, 64'h0123_4567_89AB_CDEF);
    access(1, 2'd0, 0, 'h1050, 64'h5A, 3, got);
    access(0, 2'd0, 0, 'h1050, 0, 0, got);
    chk("lit_store_alloc", got, 64'h5A);
    access(0, 2'd3, 0, 'h7FFF8, 0, 0, got);
    access(0, 2'd1, 1, 'h7FFFE, 0, 0, got);
`ifdef CACHE_L1_DATA_PERF_EN
    chk("perf_hit", perf_hit_o, m_hit);
    chk("perf_miss", perf_miss_o, m_miss);
    chk("perf_wb", perf_wb_o, m_wb);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
